// File: rtl/mem_access.sv
// mem_access: load/store stage over a req/gnt/rvalid data port, plus the MEM/WB output register.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        valid_in,
    input  logic [31:0] exec_data_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] next_pc_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  res_src_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] exec_data_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] next_pc_out,
    output logic [1:0]  res_src_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        misalign_out
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state;
    logic [31:0] l_addr, l_wdata, l_data, l_next_pc;
    logic [3:0]  l_wstrb;
    logic [2:0]  l_funct3;
    logic [1:0]  l_res_src;
    logic [4:0]  l_rd;
    logic        l_we, l_reg_write, l_bad;
    logic        is_mem, legal, aligned, bad, accept, go, take;
    logic [31:0] wdata, load_data;
    logic [3:0]  wstrb;
    logic [7:0]  lb;
    logic [15:0] lh;
    always_comb begin
        is_mem = mem_read_in | mem_write_in;
        legal = mem_write_in ? funct3_in < 3'd3 : funct3_in != 3'b011 && funct3_in[2:1] != 2'b11;
        aligned = funct3_in[1] ? exec_data_in[1:0] == 2'b00 : funct3_in[0] ? !exec_data_in[0] : 1'b1;
        bad = is_mem & !(legal & aligned);
        accept = valid_in & !flush;
        go = accept & is_mem & !bad;
        take = (state == IDLE || state == DONE) && !stall;
        wdata = funct3_in[1] ? store_data_in : funct3_in[0] ? {2{store_data_in[15:0]}} : {4{store_data_in[7:0]}};
        wstrb = !mem_write_in ? 4'b0000 : funct3_in[1] ? 4'b1111 : (funct3_in[0] ? 4'b0011 : 4'b0001) << exec_data_in[1:0];
        lb = dmem_rdata[{l_addr[1:0], 3'b000} +: 8];
        lh = dmem_rdata[{l_addr[1], 4'b0000} +: 16];
        load_data = l_funct3[1] ? dmem_rdata : l_funct3[0] ? {{16{~l_funct3[2] & lh[15]}}, lh} : {{24{~l_funct3[2] & lb[7]}}, lb};
    end
    assign stall_out  = stall | state == REQ | state == WAIT | ((state == IDLE || state == DONE) & go);
    assign dmem_req   = state == REQ;
    assign dmem_we    = l_we;
    assign dmem_addr  = {l_addr[31:2], 2'b00};
    assign dmem_wdata = l_wdata;
    assign dmem_wstrb = l_wstrb;
    // Bus handshakes advance REQ/WAIT even under stall so a grant or response is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            {l_addr, l_wdata, l_data, l_next_pc, l_wstrb, l_funct3, l_res_src, l_rd, l_we, l_reg_write, l_bad} <= '0;
            {valid_out, exec_data_out, mem_data_out, next_pc_out, res_src_out, rd_out, reg_write_out, misalign_out} <= '0;
        end else begin
            if (take) begin
                l_addr <= exec_data_in;
                l_wdata <= wdata;
                l_wstrb <= wstrb;
                l_funct3 <= funct3_in;
                l_next_pc <= next_pc_in;
                l_res_src <= res_src_in;
                l_rd <= rd_in;
                l_we <= mem_write_in;
                l_reg_write <= reg_write_in;
                l_bad <= bad;
                l_data <= '0;
            end
            case (state)
                IDLE: if (!stall) begin
                    valid_out <= accept & !go;
                    reg_write_out <= accept & !go & !bad & reg_write_in;
                    misalign_out <= accept & bad;
                    exec_data_out <= exec_data_in;
                    next_pc_out <= next_pc_in;
                    res_src_out <= res_src_in;
                    rd_out <= rd_in;
                    mem_data_out <= '0;
                    state <= go ? REQ : IDLE;
                end
                REQ: begin
                    if (!stall) {valid_out, reg_write_out, misalign_out} <= '0;
                    if (dmem_gnt) state <= l_we ? DONE : WAIT;
                end
                WAIT: begin
                    if (!stall) {valid_out, reg_write_out, misalign_out} <= '0;
                    if (dmem_rvalid) begin
                        l_data <= load_data;
                        state <= DONE;
                    end
                end
                DONE: if (!stall) begin
                    valid_out <= 1'b1;
                    reg_write_out <= l_reg_write & !l_bad;
                    misalign_out <= l_bad;
                    exec_data_out <= l_addr;
                    next_pc_out <= l_next_pc;
                    res_src_out <= l_res_src;
                    rd_out <= l_rd;
                    mem_data_out <= l_data;
                    // A non-memory op arriving here is parked in the latch and retired next cycle.
                    state <= go ? REQ : accept ? DONE : IDLE;
                end
            endcase
        end
    end
endmodule
